// File: rtl/rvv_backend_rs_fifo.sv
// Multi-push / multi-pop reservation-station FIFO feeding one RVV execution unit.
// Optional occupancy/high-water outputs are enabled by defining RVV_RS_FIFO_OCCUPANCY_EN.
`ifndef NUM_DP_UOP
`define NUM_DP_UOP 2
`endif

module rvv_backend_rs_fifo #(
  parameter int DEPTH    = 8,
  parameter int NUM_PUSH = `NUM_DP_UOP,
  parameter int NUM_POP  = 2,
  parameter int DWIDTH   = 64,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PUSH-1:0]          push_valid,
  input  logic [NUM_PUSH*DWIDTH-1:0]   push_data,
  output logic [NUM_PUSH-1:0]          push_ready,
  output logic [NUM_POP-1:0]           pop_valid,
  output logic [NUM_POP*DWIDTH-1:0]    pop_data,
  input  logic [NUM_POP-1:0]           pop_ready,
  input  logic                         flush,
  output logic                         full,
`ifdef RVV_RS_FIFO_OCCUPANCY_EN
  output logic [CNT_W-1:0]             occupancy,
  output logic [CNT_W-1:0]             high_water,
`endif
  output logic                         empty
);

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] npush;
  logic [CNT_W-1:0] npop;
  logic             push_run;
  logic             pop_run;

  logic             wr_en   [NUM_PUSH];
  logic [PTR_W-1:0] wr_addr [NUM_PUSH];

  // Ready and valid come only from registered count, so dispatch never sees
  // a combinational path from pop_ready or push_valid back to push_ready.
  always_comb begin
    free_slots = CNT_W'(DEPTH) - count_q;
    for (int i = 0; i < NUM_PUSH; i++) begin
      push_ready[i] = free_slots > CNT_W'(i);
    end
    for (int j = 0; j < NUM_POP; j++) begin
      pop_valid[j] = count_q > CNT_W'(j);
      pop_data[j*DWIDTH +: DWIDTH] = mem[rd_ptr_q + PTR_W'(j)];
    end
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Only the leading run of accepted ports counts; anything after a gap is dropped.
  always_comb begin
    npush    = '0;
    push_run = 1'b1;
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (push_run && push_valid[i] && push_ready[i]) begin
        npush = npush + CNT_W'(1);
      end else begin
        push_run = 1'b0;
      end
    end

    npop    = '0;
    pop_run = 1'b1;
    for (int j = 0; j < NUM_POP; j++) begin
      if (pop_run && pop_ready[j] && pop_valid[j]) begin
        npop = npop + CNT_W'(1);
      end else begin
        pop_run = 1'b0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_PUSH; k++) begin
      wr_en[k]   = !flush && (CNT_W'(k) < npush);
      wr_addr[k] = wr_ptr_q + PTR_W'(k);
    end
  end

  always_comb begin
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(npush);
      rd_ptr_d = rd_ptr_q + PTR_W'(npop);
      count_d  = count_q + npush - npop;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the payload array has no reset; count gates every read, so stale
  // contents are never observed and the array can map onto plain RAM cells.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PUSH; k++) begin
      if (wr_en[k]) begin
        mem[wr_addr[k]] <= push_data[k*DWIDTH +: DWIDTH];
      end
    end
  end

`ifdef RVV_RS_FIFO_OCCUPANCY_EN
  logic [CNT_W-1:0] high_water_q, high_water_d;

  always_comb begin
    if (flush) begin
      high_water_d = '0;
    end else if (count_d > high_water_q) begin
      high_water_d = count_d;
    end else begin
      high_water_d = high_water_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_water_q <= '0;
    end else begin
      high_water_q <= high_water_d;
    end
  end

  assign occupancy  = count_q;
  assign high_water = high_water_q;
`endif

`ifndef SYNTHESIS
  function automatic logic push_is_prefix(input logic [NUM_PUSH-1:0] v);
    return ((v & (v + NUM_PUSH'(1))) == '0);
  endfunction

  function automatic logic pop_is_prefix(input logic [NUM_POP-1:0] v);
    return ((v & (v + NUM_POP'(1))) == '0);
  endfunction

  // Protocol checks report and carry on; the datapath already drops non-prefix bits.
  always @(posedge clk) begin
    if (rst_n) begin
      push_prefix_chk : assert (push_is_prefix(push_valid))
        else $warning("rs_fifo: push_valid %b is not a contiguous prefix", push_valid);
      pop_prefix_chk : assert (pop_is_prefix(pop_ready))
        else $warning("rs_fifo: pop_ready %b is not a contiguous prefix", pop_ready);
      count_range_chk : assert (count_q <= CNT_W'(DEPTH))
        else $error("rs_fifo: count %0d exceeds depth", count_q);
    end
  end
`endif

endmodule

// File: tb/tb_rvv_backend_rs_fifo.sv
// Self-checking bench for rvv_backend_rs_fifo: vector table plus a data scoreboard.
module tb_rvv_backend_rs_fifo;

  localparam int DEPTH = 8;
  localparam int NP    = 2;
  localparam int NQ    = 2;
  localparam int DW    = 64;
  localparam int CW    = 4;
  localparam int NV    = 27;

  logic              clk;
  logic              rst_n;
  logic [NP-1:0]     push_valid;
  logic [NP*DW-1:0]  push_data;
  logic [NP-1:0]     push_ready;
  logic [NQ-1:0]     pop_valid;
  logic [NQ*DW-1:0]  pop_data;
  logic [NQ-1:0]     pop_ready;
  logic              flush;
  logic              full;
  logic              empty;
`ifdef RVV_RS_FIFO_OCCUPANCY_EN
  logic [CW-1:0]     occupancy;
  logic [CW-1:0]     high_water;
`endif

  rvv_backend_rs_fifo #(
    .DEPTH(DEPTH), .NUM_PUSH(NP), .NUM_POP(NQ), .DWIDTH(DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_ready  (pop_ready),
    .flush      (flush),
    .full       (full),
`ifdef RVV_RS_FIFO_OCCUPANCY_EN
    .occupancy  (occupancy),
    .high_water (high_water),
`endif
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] pv;
    logic [NQ-1:0] pr;
    logic          fl;
    int            exp_cnt;
    string         name;
  } vec_t;

  vec_t        vecs [NV];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] tag;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flags come from the table's expected count; data comes from the scoreboard.
  task automatic check_state(input string name, input int exp_cnt);
    logic [NP-1:0] epr;
    logic [NQ-1:0] epv;
    for (int i = 0; i < NP; i++) epr[i] = (DEPTH - exp_cnt) > i;
    for (int j = 0; j < NQ; j++) epv[j] = exp_cnt > j;
    check({name, " push_ready"}, DW'(push_ready), DW'(epr));
    check({name, " pop_valid"},  DW'(pop_valid),  DW'(epv));
    check({name, " full"},       DW'(full),       DW'(exp_cnt == DEPTH));
    check({name, " empty"},      DW'(empty),      DW'(exp_cnt == 0));
    for (int j = 0; j < NQ; j++) begin
      if (j < exp_cnt && j < sb.size()) begin
        check($sformatf("%s pop_data[%0d]", name, j), pop_data[j*DW +: DW], sb[j]);
      end
    end
  endtask

  task automatic apply(input logic [NP-1:0] pv, input logic [NQ-1:0] pr,
                       input logic fl, input int exp_cnt, input string name);
    int np;
    int nq;
    int fill;
    bit run;
    fill = sb.size();
    push_valid = pv;
    pop_ready  = pr;
    flush      = fl;
    for (int i = 0; i < NP; i++) push_data[i*DW +: DW] = tag + DW'(i);
    np  = 0;
    run = 1'b1;
    for (int i = 0; i < NP; i++) begin
      if (run && pv[i] && (DEPTH - fill) > i) np++;
      else run = 1'b0;
    end
    nq  = 0;
    run = 1'b1;
    for (int j = 0; j < NQ; j++) begin
      if (run && pr[j] && fill > j) nq++;
      else run = 1'b0;
    end
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      repeat (nq) void'(sb.pop_front());
      for (int k = 0; k < np; k++) sb.push_back(tag + DW'(k));
    end
    tag        = tag + DW'(NP);
    push_valid = '0;
    pop_ready  = '0;
    flush      = 1'b0;
    check_state(name, exp_cnt);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tag    = 64'hA5A5_0000_0000_0100;

    vecs[0]  = '{2'b00, 2'b00, 1'b0, 0, "idle"};
    vecs[1]  = '{2'b11, 2'b00, 1'b0, 2, "dual_push_ab"};
    vecs[2]  = '{2'b11, 2'b00, 1'b0, 4, "fill_4"};
    vecs[3]  = '{2'b11, 2'b00, 1'b0, 6, "fill_6"};
    vecs[4]  = '{2'b01, 2'b00, 1'b0, 7, "fill_7"};
    vecs[5]  = '{2'b11, 2'b00, 1'b0, 8, "fill_8_one_taken"};
    vecs[6]  = '{2'b11, 2'b00, 1'b0, 8, "push_while_full"};
    vecs[7]  = '{2'b11, 2'b01, 1'b0, 7, "pop_at_full"};
    vecs[8]  = '{2'b00, 2'b11, 1'b0, 5, "pop_2"};
    vecs[9]  = '{2'b00, 2'b01, 1'b0, 4, "pop_1"};
    vecs[10] = '{2'b11, 2'b01, 1'b0, 5, "sim_1"};
    vecs[11] = '{2'b11, 2'b01, 1'b0, 6, "sim_2"};
    vecs[12] = '{2'b11, 2'b01, 1'b0, 7, "sim_3_wrap"};
    vecs[13] = '{2'b00, 2'b11, 1'b0, 5, "drain_a"};
    vecs[14] = '{2'b00, 2'b11, 1'b0, 3, "drain_b"};
    vecs[15] = '{2'b10, 2'b00, 1'b0, 3, "nonprefix_push"};
    vecs[16] = '{2'b00, 2'b10, 1'b0, 3, "nonprefix_pop"};
    vecs[17] = '{2'b00, 2'b11, 1'b0, 1, "drain_c"};
    vecs[18] = '{2'b00, 2'b01, 1'b0, 0, "drain_d"};
    vecs[19] = '{2'b00, 2'b11, 1'b0, 0, "pop_empty"};
    vecs[20] = '{2'b11, 2'b00, 1'b0, 2, "refill_2"};
    vecs[21] = '{2'b11, 2'b00, 1'b0, 4, "refill_4"};
    vecs[22] = '{2'b11, 2'b00, 1'b0, 6, "refill_6"};
    vecs[23] = '{2'b11, 2'b11, 1'b1, 0, "flush_push"};
    vecs[24] = '{2'b01, 2'b00, 1'b0, 1, "post_flush_push"};
    vecs[25] = '{2'b11, 2'b01, 1'b0, 2, "push2_pop1"};
    vecs[26] = '{2'b00, 2'b11, 1'b0, 0, "final_drain"};

    rst_n      = 1'b0;
    push_valid = '0;
    pop_ready  = '0;
    flush      = 1'b0;
    push_data  = '0;
    #1;
    check_state("in_reset", 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("after_reset", 0);

    for (int v = 0; v < NV; v++) begin
      apply(vecs[v].pv, vecs[v].pr, vecs[v].fl, vecs[v].exp_cnt, vecs[v].name);
`ifdef RVV_RS_FIFO_OCCUPANCY_EN
      check({vecs[v].name, " occupancy"}, DW'(occupancy), DW'(vecs[v].exp_cnt));
      if (vecs[v].fl) check({vecs[v].name, " high_water"}, DW'(high_water), '0);
`endif
    end

    // Asynchronous reset in the middle of a cycle discards stored entries at once.
    apply(2'b11, 2'b00, 1'b0, 2, "pre_async_reset");
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("async_reset pop_valid", DW'(pop_valid), '0);
    check("async_reset empty", DW'(empty), DW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("after_async_reset", 0);
    apply(2'b11, 2'b00, 1'b0, 2, "push_after_reset");
    apply(2'b00, 2'b11, 1'b0, 0, "drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rvv_backend_rs_fifo.md
Name: rvv_backend_rs_fifo

Overview:
- Multi-push / multi-pop reservation-station FIFO on the dispatch side of the RVV backend.
- Receives up to NUM_PUSH uops per cycle from dispatch, using per-port valid/ready with in-order prefix semantics.
- Presents up to NUM_POP oldest entries per cycle to an execution unit (ALU, MUL, PMTRDT, DIV, LSU).
- One instance per execution unit; ready outputs drive the dispatch rs_ready_*2dp inputs.

Parameters:
- DEPTH, 8: number of entries. Power of two, >= max(NUM_PUSH, NUM_POP).
- NUM_PUSH, `NUM_DP_UOP (2): number of push ports.
- NUM_POP, 2: number of pop ports.
- DWIDTH, 64: payload width per entry (opaque uop struct bits).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- push_valid, input, NUM_PUSH: per-port push request; must be a contiguous prefix from bit 0.
- push_data, input, NUM_PUSH*DWIDTH: push payloads; port i occupies bits [i*DWIDTH +: DWIDTH].
- push_ready, output, NUM_PUSH: bit i=1 means at least i+1 free entries.
- pop_valid, output, NUM_POP: bit j=1 means at least j+1 valid entries.
- pop_data, output, NUM_POP*DWIDTH: oldest-first entries; port 0 is the oldest.
- pop_ready, input, NUM_POP: consumer accepts; contiguous prefix from bit 0.
- flush, input, 1: synchronous clear of all entries (trap/kill).
- full, output, 1: count==DEPTH.
- empty, output, 1: count==0.

Behaviour:
- State:
  - mem[DEPTH] payload array, not reset.
  - wr_ptr, rd_ptr: log2(DEPTH) bits, wrap naturally modulo DEPTH.
  - count: log2(DEPTH)+1 bits.
  - All reset to 0 asynchronously on rst_n low.
- Reset outputs: push_ready all 1, pop_valid all 0, pop_data don't-care, full=0, empty=1.
- push_ready[i] = (DEPTH - count) > i.
  - Depends only on registered count, with no combinational path from pop_ready or push_valid. This breaks the dispatch ready chain loop.
- pop_valid[j] = count > j.
- pop_data[j] = mem[(rd_ptr + j) mod DEPTH]. Zero-latency read of registered storage.
- Push count:
  - npush = number of leading ones of (push_valid & push_ready).
  - Bits after the first zero are ignored, and no entry is written for them.
  - Entry k of the accepted prefix is written at mem[(wr_ptr + k) mod DEPTH].
- Pop count:
  - npop = number of leading ones of (pop_valid & pop_ready).
  - Non-prefix patterns are treated the same way as on the push side.
- Pointer and count update each cycle:
  - wr_ptr += npush.
  - rd_ptr += npop.
  - count = count + npush - npop.
- Simultaneous push and pop:
  - Both apply in the same cycle.
  - Freed slots become pushable only on the next cycle; there is no same-cycle bypass.
  - A write into a slot being popped in the same cycle cannot occur, because the ready rule excludes it.
- Empty: no bypass from push to pop. A pushed entry appears on pop_valid[0] one cycle after the push edge (latency 1).
- Full: push_ready = 0. A pop in that cycle frees space for the next cycle only.
- Wrap-around: pushes and pops spanning index DEPTH-1 to 0 must keep order.
- flush:
  - Next edge sets wr_ptr = rd_ptr = count = 0.
  - Overrides any push or pop that cycle.
  - Outputs then match the reset values.
- Reset mid-operation: all in-flight contents are discarded immediately (asynchronous). No pop_valid until new pushes arrive.
- Protocol checks: simulation-only assertions fire on a non-prefix push_valid or pop_ready, and on count > DEPTH.

Optional Feature:
- Macro: RVV_RS_FIFO_OCCUPANCY_EN.
- When defined, add two outputs:
  - occupancy (log2(DEPTH)+1 bits): mirrors count.
  - high_water (log2(DEPTH)+1 bits): registered maximum of count since reset or flush. Reset value 0; flush clears it to 0; it updates on the cycle count exceeds it.
- When undefined, neither port nor register exists, and behaviour is otherwise identical.

Test Plan:
- Reset then idle → empty=1, full=0, push_ready=2'b11, pop_valid=2'b00.
- Dual push A,B with pop_ready=0 → next cycle count=2, pop_valid=2'b11, pop_data[0]=A, pop_data[1]=B.
- Fill to 8 with pop_ready=0:
  - At count=7: push_ready=2'b01.
  - At count=8: full=1, push_ready=2'b00.
  - push_valid=2'b11 while full → count remains 8.
- Simultaneous operation at count=4: push 2 and pop 1 each cycle for 3 cycles → count 5,6,7. Data emerges in strict insertion order across the pointer wrap 7→0.
- push_valid=2'b10 (non-prefix) → nothing written, count unchanged, assertion flags it.
- Flush at count=6 while pushing 2 → next cycle count=0, empty=1, pop_valid=0. With the macro defined, high_water reads 0.
